// File: rtl/jt51_opmix_if.sv
// Operator-to-mixer bus: per-slot operator data in, saturated stereo sample out.
// No backpressure: the mixer consumes one slot per clock, unconditionally.
interface jt51_opmix_if;
   logic               sync;
   logic signed [13:0] op_out;
   logic [1:0]         rl;
   logic signed [15:0] left;
   logic signed [15:0] right;
   logic               sample;
   logic               sync_err;

   modport master (
      output sync, op_out, rl,
      input  left, right, sample, sync_err
   );

   modport slave (
      input  sync, op_out, rl,
      output left, right, sample, sync_err
   );
endinterface

// File: rtl/jt51_opmix.sv
// Sums 32 operator slots per frame onto L/R buses and emits a saturated stereo sample.
// Latency: slot 31 on cycle t gives left/right/sample on t+1; no backpressure, one slot per clock.
module jt51_opmix (
   input logic         clk,
   input logic         rst_n,
   jt51_opmix_if.slave bus
);

   typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_t;

   state_t             r_state, w_state_nxt;
   logic [4:0]         r_cnt, w_cnt_nxt;
   logic signed [18:0] r_acc_l, r_acc_r, w_acc_l_nxt, w_acc_r_nxt;
   logic signed [15:0] r_left, r_right, w_left_nxt, w_right_nxt;
   logic               r_sample, w_sample_nxt;
   logic               r_sync_err, w_sync_err_nxt;

   logic signed [18:0] w_op_sx, w_term_l, w_term_r, w_sum_l, w_sum_r;
   logic               w_locked, w_slot0, w_misalign, w_last;

   function automatic logic signed [15:0] sat16(input logic signed [18:0] v);
      if (v > 19'sd32767)
         return 16'sh7fff;
      else if (v < -19'sd32768)
         return 16'sh8000;
      else
         return v[15:0];
   endfunction

   assign w_op_sx  = {{5{bus.op_out[13]}}, bus.op_out};
   assign w_term_l = bus.rl[1] ? w_op_sx : 19'sd0;
   assign w_term_r = bus.rl[0] ? w_op_sx : 19'sd0;
   assign w_sum_l  = r_acc_l + w_term_l;
   assign w_sum_r  = r_acc_r + w_term_r;

   assign w_locked   = (r_state == ST_LOCKED);
   assign w_misalign = w_locked && bus.sync && (r_cnt != 5'd0);
   assign w_slot0    = bus.sync || (r_cnt == 5'd0);
   // A resync landing on slot 31 discards that frame rather than closing it.
   assign w_last     = w_locked && (r_cnt == 5'd31) && !bus.sync;

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_acc_l_nxt    = r_acc_l;
      w_acc_r_nxt    = r_acc_r;
      w_left_nxt     = r_left;
      w_right_nxt    = r_right;
      w_sample_nxt   = 1'b0;
      w_sync_err_nxt = r_sync_err || w_misalign;

      if (w_locked || bus.sync) begin
         w_state_nxt = ST_LOCKED;
         w_cnt_nxt   = w_slot0 ? 5'd1 : r_cnt + 5'd1;
         w_acc_l_nxt = w_slot0 ? w_term_l : w_sum_l;
         w_acc_r_nxt = w_slot0 ? w_term_r : w_sum_r;
      end

      if (w_last) begin
         w_left_nxt   = sat16(w_sum_l);
         w_right_nxt  = sat16(w_sum_r);
         w_sample_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_UNLOCKED;
         r_cnt      <= 5'd0;
         r_acc_l    <= 19'sd0;
         r_acc_r    <= 19'sd0;
         r_left     <= 16'sd0;
         r_right    <= 16'sd0;
         r_sample   <= 1'b0;
         r_sync_err <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_acc_l    <= w_acc_l_nxt;
         r_acc_r    <= w_acc_r_nxt;
         r_left     <= w_left_nxt;
         r_right    <= w_right_nxt;
         r_sample   <= w_sample_nxt;
         r_sync_err <= w_sync_err_nxt;
      end
   end

   assign bus.left     = r_left;
   assign bus.right    = r_right;
   assign bus.sample   = r_sample;
   assign bus.sync_err = r_sync_err;

endmodule

// File: tb/tb_jt51_opmix.sv
// Directed bench for jt51_opmix: lock, sums, gating, saturation, resync and reset-abort.
module tb_jt51_opmix;

   logic clk;
   logic rst_n;
   int   n_assert;
   int   n_fail;
   int   n_strobe;
   int   s0;

   jt51_opmix_if bus ();

   jt51_opmix dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one slot, let the edge take it, then sample outputs 1 time unit later.
   task automatic slot(input logic s, input logic signed [13:0] d, input logic [1:0] r);
      bus.sync   = s;
      bus.op_out = d;
      bus.rl     = r;
      @(posedge clk);
      #1;
      if (bus.sample === 1'b1) n_strobe++;
   endtask

   initial begin
      n_assert   = 0;
      n_fail     = 0;
      n_strobe   = 0;
      rst_n      = 1'b0;
      bus.sync   = 1'b0;
      bus.op_out = 14'sd0;
      bus.rl     = 2'b00;

      // Reset state
      slot(1'b0, 14'sd0, 2'b00);
      slot(1'b0, 14'sd0, 2'b00);
      check("rst_left", $signed(bus.left), 0);
      check("rst_right", $signed(bus.right), 0);
      check("rst_sample", bus.sample, 0);
      check("rst_sync_err", bus.sync_err, 0);
      rst_n = 1'b1;

      // Unlocked: inputs ignored
      n_strobe = 0;
      for (int i = 0; i < 100; i++) slot(1'b0, 14'sd100, 2'b11);
      check("unlocked_strobes", n_strobe, 0);
      check("unlocked_left", $signed(bus.left), 0);
      check("unlocked_right", $signed(bus.right), 0);
      check("unlocked_sync_err", bus.sync_err, 0);

      // Lock; all ones for one frame
      s0 = n_strobe;
      slot(1'b1, 14'sd1, 2'b11);
      for (int i = 1; i < 31; i++) slot(1'b0, 14'sd1, 2'b11);
      check("lock_no_early_strobe", n_strobe, s0);
      slot(1'b0, 14'sd1, 2'b11);
      check("lock_strobe", bus.sample, 1);
      check("lock_left", $signed(bus.left), 32);
      check("lock_right", $signed(bus.right), 32);

      // Free-running second frame, no sync
      slot(1'b0, 14'sd1, 2'b11);
      check("strobe_one_cycle", bus.sample, 0);
      s0 = n_strobe;
      for (int i = 1; i < 31; i++) slot(1'b0, 14'sd1, 2'b11);
      check("free_no_early_strobe", n_strobe, s0);
      slot(1'b0, 14'sd1, 2'b11);
      check("free_strobe", bus.sample, 1);
      check("free_left", $signed(bus.left), 32);
      check("free_right", $signed(bus.right), 32);

      // Gating: evens to right, odds to left, aligned sync
      for (int i = 0; i < 32; i++)
         slot(i == 0, 14'(i), (i % 2 == 0) ? 2'b01 : 2'b10);
      check("gate_strobe", bus.sample, 1);
      check("gate_left", $signed(bus.left), 256);
      check("gate_right", $signed(bus.right), 240);
      check("aligned_sync_no_err", bus.sync_err, 0);

      // Saturation both directions
      for (int i = 0; i < 32; i++) slot(1'b0, 14'sd8191, 2'b11);
      check("satp_left", $signed(bus.left), 32767);
      check("satp_right", $signed(bus.right), 32767);
      for (int i = 0; i < 32; i++) slot(1'b0, -14'sd8192, 2'b11);
      check("satn_left", $signed(bus.left), -32768);
      check("satn_right", $signed(bus.right), -32768);

      // Misaligned sync at slot 10
      for (int i = 0; i < 10; i++) slot(1'b0, 14'sd1000, 2'b11);
      check("pre_misalign_err", bus.sync_err, 0);
      s0 = n_strobe;
      slot(1'b1, 14'sd5, 2'b11);
      check("misalign_err", bus.sync_err, 1);
      for (int i = 1; i < 31; i++) slot(1'b0, 14'sd5, 2'b11);
      check("misalign_no_old_strobe", n_strobe, s0);
      check("misalign_left_held", $signed(bus.left), -32768);
      slot(1'b0, 14'sd5, 2'b11);
      check("misalign_strobe", bus.sample, 1);
      check("misalign_left", $signed(bus.left), 160);
      check("misalign_right", $signed(bus.right), 160);
      check("misalign_err_sticky", bus.sync_err, 1);

      // Resync on slot 31 discards that frame
      s0 = n_strobe;
      for (int i = 0; i < 31; i++) slot(1'b0, 14'sd7, 2'b11);
      slot(1'b1, -14'sd3, 2'b01);
      check("resync31_no_strobe", n_strobe, s0);
      for (int i = 1; i < 31; i++) slot(1'b0, -14'sd3, 2'b01);
      check("resync31_quiet", n_strobe, s0);
      slot(1'b0, -14'sd3, 2'b01);
      check("resync31_strobe", bus.sample, 1);
      check("resync31_left", $signed(bus.left), 0);
      check("resync31_right", $signed(bus.right), -96);

      // Reset mid-frame aborts and unlocks
      for (int i = 0; i < 20; i++) slot(i == 0, 14'sd50, 2'b11);
      rst_n = 1'b0;
      slot(1'b0, 14'sd50, 2'b11);
      check("midrst_left", $signed(bus.left), 0);
      check("midrst_right", $signed(bus.right), 0);
      check("midrst_sample", bus.sample, 0);
      check("midrst_sync_err", bus.sync_err, 0);
      rst_n = 1'b1;
      s0 = n_strobe;
      for (int i = 0; i < 40; i++) slot(1'b0, 14'sd9, 2'b11);
      check("midrst_unlocked", n_strobe, s0);
      slot(1'b1, 14'sd2, 2'b11);
      for (int i = 1; i < 31; i++) slot(1'b0, 14'sd2, 2'b11);
      check("relock_no_early", n_strobe, s0);
      slot(1'b0, 14'sd2, 2'b11);
      check("relock_strobe", bus.sample, 1);
      check("relock_left", $signed(bus.left), 64);
      check("relock_right", $signed(bus.right), 64);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/jt51_opmix.md
# jt51_opmix

Per-sample mixing accumulator directly downstream of the pipelined FM operator stage. Consumes the operator's signed 14-bit output, one value per slot over the 32-slot frame (8 channels × 4 operators), gates each value onto the left and/or right bus, and sums each bus over the frame. At each frame end it saturates both sums to 16 bits and presents them with a one-cycle sample strobe. The operator stage already zeroes non-carrier slots, so this block sums every slot unconditionally apart from the L/R gating.

## Interface

Parameters:
- none; widths are fixed by the operator output format.

Ports:
- clk  input  1  system clock, same clock as the operator pipeline.
- rst_n  input  1  reset, synchronous, active-low; one clock, synchronous active-low reset.
- sync  input  1  frame marker; high on the cycle carrying slot 0 data.
- op_out  input  14  signed operator output for the current slot.
- rl  input  2  channel routing for the current slot, aligned with op_out; rl[1] selects left, rl[0] selects right.
- left  output  16  signed saturated left sum for the last complete frame.
- right  output  16  signed saturated right sum for the last complete frame.
- sample  output  1  one-cycle strobe; high when left and right have just been updated.
- sync_err  output  1  sticky flag; set when sync arrives mid-frame.

## Operation

- State machine:
  - UNLOCKED: the state after reset. Inputs are ignored, no accumulation, sample stays 0. sync=1 moves to LOCKED, and that cycle is treated as slot 0 with no error.
  - LOCKED: a 5-bit slot counter advances every cycle and wraps 31→0 without needing a new sync.
- Slot terms:
  - term_l = rl[1] ? sext(op_out) : 0.
  - term_r = rl[0] ? sext(op_out) : 0.
  - Both terms are sign-extended to 19 bits.
- Accumulators acc_l and acc_r are 19-bit signed. Range is -262144..262143, which covers 32 × [-8192, 8191] with no overflow.
  - Slot 0 (by counter, or forced by sync): acc ← term. The previous frame is discarded.
  - Slots 1..31: acc ← acc + term.
  - Slot 31 also does: left ← sat16(acc_l + term_l), right ← sat16(acc_r + term_r), sample ← 1.
- sat16 clamps the value to the range -32768..32767.
- left and right hold their value between strobes.
- sync while LOCKED with counter == 0 is an aligned sync: normal operation, no error.
- sync while LOCKED with counter != 0 is a misaligned sync:
  - sync_err ← 1 (sticky).
  - The partial frame is discarded: no sample strobe, left and right unchanged.
  - That cycle is treated as slot 0 and the counter is set to 1 for the next cycle.
- Misaligned sync on a cycle where the counter is 31: the resync wins. No strobe is produced for that frame.
- sync_err is cleared only by reset.

## Timing

- Reset values:
  - left = 0, right = 0, sample = 0, sync_err = 0.
  - State UNLOCKED, counter = 0, acc_l = acc_r = 0.
- Reset asserted mid-frame aborts the frame. No strobe is produced, and the block returns to UNLOCKED.
- Latency: slot 31 data on cycle t produces left/right valid and sample = 1 on cycle t+1 (one register stage). sample is low on cycle t+2 unless the frame length is 1, which cannot happen.
- Strobe rate: in steady LOCKED state with no misaligned sync, sample pulses exactly once every 32 cycles.
- First strobe after lock: 32 cycles after the locking sync cycle.
  - Locking sync on cycle s means slot 31 is on cycle s+31, and sample is high on cycle s+32.
- After a misaligned sync on cycle s, the next strobe is on cycle s+32.
- rl and op_out are sampled on the same edge. There is no internal skew compensation; alignment is the upstream's responsibility.

## Test plan

- Reset, then 100 cycles with op_out=100, rl=2'b11, sync=0 → sample never high; left=right=0; sync_err=0.
- Sync on cycle s, then 32 slots with op_out=1, rl=2'b11 → sample high only on cycle s+32; left=right=32; repeating the frame without sync gives a strobe at s+64 with the same values.
- Same frame but rl=2'b01 on even slots and rl=2'b10 on odd slots, op_out=slot index (0..31) → right=240, left=256.
- All 32 slots op_out=8191, rl=2'b11 → left=right=32767. Next frame all op_out=-8192 → left=right=-32768.
- Lock, run 10 slots, assert sync at slot 10 → sync_err=1 and stays 1. No strobe at the old frame end. Strobe 32 cycles after the resync, with the sum of the new frame only.
- Lock, run 20 slots, drop rst_n for one cycle → outputs are 0 and the state is UNLOCKED. No strobe until a new sync plus 32 cycles.
